// File: rtl/mc_iter_engine.sv
// rtl/mc_iter_engine.sv - Iterative AES MixColumns/InvMixColumns engine
//
// Accepts a 128-bit AES state over a valid/ready handshake and transforms
// NCPC columns per clock over 4/NCPC cycles. The result is held until the
// downstream side accepts it.
//
// Parameters:
//   NCPC    columns processed per cycle (1, 2 or 4)
//   INV_EN  1 keeps the InvMixColumns logic, 0 removes it (forward only)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input transaction valid
//   in_ready   engine can accept an input (IDLE)
//   in_inv     1 = InvMixColumns, 0 = MixColumns; sampled on accept
//   state_in   input state; byte i = [8i+7:8i], column c = bytes 4c..4c+3
//   out_valid  result valid (DONE)
//   out_ready  downstream accepts result
//   state_out  result state, same packing as state_in
//   busy       high in BUSY or DONE

module mc_iter_engine #(
    parameter int NCPC   = 1,
    parameter int INV_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    generate
        if (NCPC != 1 && NCPC != 2 && NCPC != 4) begin : g_bad_ncpc
            $error("mc_iter_engine: NCPC must be 1, 2 or 4");
        end
    endgenerate

    localparam int         GROUPS    = 4 / NCPC;
    localparam logic [1:0] LAST_GRP  = 2'(GROUPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       fsm;
    logic [1:0]   cnt;
    logic         inv_q;
    logic [127:0] res_q;
    logic [127:0] res_next;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse mode reuses the forward network: the preconditioning step
    // turns the forward matrix into the inverse one.
    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic [7:0] a0, a1, a2, a3, u, v, o0, o1, o2, o3;
        a0 = c[7:0];
        a1 = c[15:8];
        a2 = c[23:16];
        a3 = c[31:24];
        u  = 8'h00;
        v  = 8'h00;
        if (inv) begin
            u  = xtime(xtime(a0 ^ a2));
            v  = xtime(xtime(a1 ^ a3));
            a0 = a0 ^ u;
            a1 = a1 ^ v;
            a2 = a2 ^ u;
            a3 = a3 ^ v;
        end
        o0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        o1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        o2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        o3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {o3, o2, o1, o0};
    endfunction

    // Only the current group of columns is rewritten; the rest of the
    // register keeps either latched input or already-finished columns.
    always_comb begin
        logic [1:0] col;
        res_next = res_q;
        col      = 2'd0;
        for (int k = 0; k < NCPC; k++) begin
            col = 2'(32'(cnt) * NCPC + k);
            res_next[{col, 5'b0} +: 32] =
                mix_col(res_q[{col, 5'b0} +: 32], (INV_EN != 0) && inv_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= ST_IDLE;
            cnt       <= 2'd0;
            inv_q     <= 1'b0;
            res_q     <= 128'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        res_q    <= state_in;
                        inv_q    <= (INV_EN != 0) ? in_inv : 1'b0;
                        cnt      <= 2'd0;
                        fsm      <= ST_BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    res_q <= res_next;
                    if (cnt == LAST_GRP) begin
                        cnt       <= 2'd0;
                        fsm       <= ST_DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        fsm       <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    fsm       <= ST_IDLE;
                    cnt       <= 2'd0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign state_out = res_q;

endmodule

// File: doc/mc_iter_engine.md
Name: mc_iter_engine

Overview:
- Sequential, parametrised MixColumns engine for the unmasked AES datapath.
- Accepts a 128-bit state over a valid/ready handshake and processes NCPC columns per cycle over 4/NCPC cycles.
- Optionally computes InvMixColumns, selected per transaction.
- Holds the result until downstream accepts it. Sits between the ShiftRows and AddRoundKey stages of an iterative round datapath.

Parameters:
- NCPC, 1, columns processed per cycle; legal values 1, 2, 4; any other value is an elaboration error.
- INV_EN, 1, 1 instantiates inverse-mode logic; 0 removes it and forces forward mode.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  engine can accept an input
- in_inv  in  1  1 = InvMixColumns, 0 = MixColumns; sampled on accept
- state_in  in  128  input state; byte i = state_in[8i+7:8i]; column c = bytes 4c..4c+3, row 0 first
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- state_out  out  128  result state, same byte and column packing as state_in
- busy  out  1  high in BUSY or DONE

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, internal column counter=0, inverse flag=0, state/result registers=0, in_ready=1 after reset release, out_valid=0, busy=0, state_out=0. Assertion mid-transaction aborts the transaction and discards data.
- FSM states:
  - IDLE: in_ready=1. in_valid=1 at an edge latches state_in and in_inv (in_inv is forced to 0 if INV_EN=0), clears the counter, and moves to BUSY.
  - BUSY: in_ready=0. Each edge transforms columns counter*NCPC .. counter*NCPC+NCPC-1, writes them into the result register, and increments the counter. After the edge that processes group G-1, with G=4/NCPC, the FSM moves to DONE. in_valid is ignored in this state.
  - DONE: out_valid=1 and state_out is stable. When out_ready=1 at an edge, move to IDLE. A new accept is impossible in that same cycle (in_ready=0 in DONE).
- Latency: out_valid is first high G edges after the accepting edge (NCPC=4 gives 1, NCPC=1 gives 4).
- Throughput: with out_ready held at 1, at most one transaction per G+2 cycles.
- Forward column transform, over GF(2^8) with polynomial 0x11b; xtime(x) = (x<<1) ^ (x[7] ? 0x1b : 0):
  - o0 = 2a0^3a1^a2^a3
  - o1 = a0^2a1^3a2^a3
  - o2 = a0^a1^2a2^3a3
  - o3 = 3a0^a1^a2^2a3
- Inverse column transform (inverse flag=1): precondition the column, then apply the forward transform.
  - u = xtime(xtime(a0^a2)), v = xtime(xtime(a1^a3)).
  - a0^=u, a1^=v, a2^=u, a3^=v.
- Only NCPC column transform instances exist. Columns not yet processed keep their latched input value in the result register; state_out exposes the register only while out_valid=1 and is otherwise don't-care.
- The counter wraps to 0 on entry to DONE. With NCPC=4 the counter is unused and BUSY lasts exactly one cycle.
- out_ready while not in DONE has no effect. Dropping in_valid while in IDLE is legal.

Test Plan:
- NCPC=1, forward; state_in column 0 = db 13 53 45 (state_in[31:0]=32'h455313db), columns 1–3 = f2 0a 22 5c, 01 01 01 01, c6 c6 c6 c6 -> out_valid exactly 4 edges after accept; state_out columns = 8e 4d a1 bc, 9f dc 58 9d, 01 01 01 01, c6 c6 c6 c6.
- Same vectors with in_inv=1 applied to the forward results -> the original columns are recovered (8e4da1bc -> db135345, 9fdc589d -> f20a225c); repeat for NCPC=2 (latency 2) and NCPC=4 (latency 1).
- Backpressure: out_ready=0 for 10 cycles after out_valid -> state_out stable, in_ready=0, and in_valid pulses with other data are ignored. Release out_ready -> IDLE next edge, then a new accept.
- Reset mid-operation: drop rst_n during BUSY counter=2 -> out_valid=0 and state_out=0 immediately; after release in_ready=1, and the next transaction produces correct results.
- INV_EN=0 with in_inv=1, input db135345 column -> forward result 8e4da1bc.
- Back-to-back streaming with out_ready=1 and in_valid=1 over 8 random states -> results match a software model, one transaction every G+2 cycles.
